// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the DataMem two-port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_OWN0 = 2'd1,
      ARB_OWN1 = 2'd2
   } arb_state_t;

   localparam logic PORT_CORE  = 1'b0;
   localparam logic PORT_AUX   = 1'b1;
   // Port 0 wins the first tie after reset.
   localparam logic LAST_RESET = PORT_AUX;

endpackage

// File: rtl/mem_arb_port_rsp.sv
// Per-port read-return register: captures MemRData on an accepted read beat.
module mem_arb_port_rsp #(
   parameter int unsigned DW = 8
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Accept,
   input  logic [DW-1:0] MemRData,
   output logic          RValid,
   output logic [DW-1:0] RData
);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         RValid <= 1'b0;
         RData  <= '0;
      end else begin
         RValid <= Accept;
         if (Accept) begin
            RData <= MemRData;
         end
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin owner arbiter for the single-port DataMem, with bounded locked bursts.
module data_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW        = 8,
   parameter int unsigned DW        = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Req0,
   input  logic          Req1,
   input  logic          Lock0,
   input  logic          Lock1,
   input  logic          We0,
   input  logic          We1,
   input  logic [AW-1:0] Addr0,
   input  logic [AW-1:0] Addr1,
   input  logic [DW-1:0] WData0,
   input  logic [DW-1:0] WData1,
   output logic          Gnt0,
   output logic          Gnt1,
   output logic          RValid0,
   output logic          RValid1,
   output logic [DW-1:0] RData0,
   output logic [DW-1:0] RData1,
   output logic [AW-1:0] MemAddr,
   output logic          MemWrEn,
   output logic [DW-1:0] MemWData,
   input  logic [DW-1:0] MemRData,
   output logic          Busy
);

   localparam int unsigned CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] BurstMax = CW'(MAX_BURST);

   arb_state_t    state, stateNext;
   logic [CW-1:0] burstCnt, burstCntNext, cntInc;
   logic          last, lastNext;

   logic accept0, accept1;
   logic ownIsAux, ownReq, ownLock, ownAccept, otherReq;
   arb_state_t otherOwn;

   assign Gnt0    = (state == ARB_OWN0);
   assign Gnt1    = (state == ARB_OWN1);
   assign Busy    = (state != ARB_IDLE);
   assign accept0 = Gnt0 && Req0;
   assign accept1 = Gnt1 && Req1;

   always_comb begin
      MemAddr  = '0;
      MemWData = '0;
      MemWrEn  = 1'b0;
      if (accept0) begin
         MemAddr  = Addr0;
         MemWData = WData0;
         MemWrEn  = We0 && !Reset;
      end else if (accept1) begin
         MemAddr  = Addr1;
         MemWData = WData1;
         MemWrEn  = We1 && !Reset;
      end
   end

   // Fold the two OWN states onto one owner/other view.
   assign ownIsAux  = (state == ARB_OWN1);
   assign ownReq    = ownIsAux ? Req1 : Req0;
   assign ownLock   = ownIsAux ? Lock1 : Lock0;
   assign otherReq  = ownIsAux ? Req0 : Req1;
   assign otherOwn  = ownIsAux ? ARB_OWN0 : ARB_OWN1;
   assign ownAccept = accept0 || accept1;
   assign cntInc    = burstCnt + 1'b1;

   always_comb begin
      stateNext    = state;
      burstCntNext = burstCnt;
      lastNext     = last;
      unique case (state)
         ARB_IDLE: begin
            burstCntNext = '0;
            if (Req0 && Req1) begin
               stateNext = (last == PORT_CORE) ? ARB_OWN1 : ARB_OWN0;
            end else if (Req0) begin
               stateNext = ARB_OWN0;
            end else if (Req1) begin
               stateNext = ARB_OWN1;
            end
         end
         ARB_OWN0, ARB_OWN1: begin
            if (ownAccept && ownLock) begin
               if (cntInc < BurstMax) begin
                  burstCntNext = cntInc;
               end else begin
                  // Burst quota used up: hand over if someone waits, else start a fresh quota.
                  burstCntNext = '0;
                  if (otherReq) begin
                     stateNext = otherOwn;
                     lastNext  = ownIsAux ? PORT_AUX : PORT_CORE;
                  end
               end
            end else begin
               burstCntNext = '0;
               lastNext     = ownIsAux ? PORT_AUX : PORT_CORE;
               stateNext    = otherReq ? otherOwn : ARB_IDLE;
            end
            if (!ownReq) begin
               stateNext = otherReq ? otherOwn : ARB_IDLE;
            end
         end
         default: begin
            stateNext    = ARB_IDLE;
            burstCntNext = '0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= ARB_IDLE;
         burstCnt <= '0;
         last     <= LAST_RESET;
      end else begin
         state    <= stateNext;
         burstCnt <= burstCntNext;
         last     <= lastNext;
      end
   end

   mem_arb_port_rsp #(
      .DW(DW)
   ) u_rsp0 (
      .Clk     (Clk),
      .Reset   (Reset),
      .Accept  (accept0 && !We0),
      .MemRData(MemRData),
      .RValid  (RValid0),
      .RData   (RData0)
   );

   mem_arb_port_rsp #(
      .DW(DW)
   ) u_rsp1 (
      .Clk     (Clk),
      .Reset   (Reset),
      .Accept  (accept1 && !We1),
      .MemRData(MemRData),
      .RValid  (RValid1),
      .RData   (RData1)
   );

endmodule
